// File: rtl/fp_defs_pkg.sv
// Shared definitions for the fp_sub_seq datapath: field widths, exponent limits, FSM states.
// Ports: none (package).
// Latency/backpressure: not applicable.
package fp_defs_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  // Packed operand width and significand width including the hidden bit.
  localparam int FP_W  = 1 + EXP_W + MAN_W;
  localparam int SIG_W = MAN_W + 1;

  // Alignment never needs more than SIG_W+1 shifts; beyond that S is already zero.
  localparam int CNT_W     = 5;
  localparam int MAX_SHIFT = 25;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_OP    = 3'd2,
    ST_NORM  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/fp_unpack.sv
// Operand unpack and magnitude ordering for fp_sub_seq (B sign inverted, L is the larger magnitude).
// Ports: a_fp/b_fp packed operands in; l_*/s_* ordered sign+exponent+significand, diff = min(eL-eS, 25) out.
// Latency: combinational; no backpressure.
module fp_unpack
  import fp_defs_pkg::*;
(
  input  logic [FP_W-1:0]  a_fp,
  input  logic [FP_W-1:0]  b_fp,
  output logic             l_sign,
  output logic             s_sign,
  output logic [EXP_W-1:0] l_exp,
  output logic [SIG_W-1:0] l_sig,
  output logic [SIG_W-1:0] s_sig,
  output logic [CNT_W-1:0] diff
);

  logic             a_sign, b_sign;
  logic [EXP_W-1:0] a_exp, b_exp, s_exp, exp_diff;
  logic             a_zero, b_zero;
  logic [SIG_W-1:0] a_sig, b_sig;
  logic             swap;

  // Subtraction is performed as addition of the negated subtrahend.
  assign a_sign = a_fp[FP_W-1];
  assign b_sign = ~b_fp[FP_W-1];
  assign a_exp  = a_fp[FP_W-2:MAN_W];
  assign b_exp  = b_fp[FP_W-2:MAN_W];

  // A zero exponent means the value is zero; no denormal support, so its significand is forced to 0.
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
  assign a_sig  = a_zero ? '0 : {1'b1, a_fp[MAN_W-1:0]};
  assign b_sig  = b_zero ? '0 : {1'b1, b_fp[MAN_W-1:0]};

  // Exponent first, then significand: a plain compare of the concatenation does both.
  assign swap = ({b_exp, b_sig} > {a_exp, a_sig});

  assign l_sign = swap ? b_sign : a_sign;
  assign s_sign = swap ? a_sign : b_sign;
  assign l_exp  = swap ? b_exp  : a_exp;
  assign s_exp  = swap ? a_exp  : b_exp;
  assign l_sig  = swap ? b_sig  : a_sig;
  assign s_sig  = swap ? a_sig  : b_sig;

  assign exp_diff = l_exp - s_exp;
  assign diff     = (exp_diff > EXP_W'(MAX_SHIFT)) ? CNT_W'(MAX_SHIFT) : exp_diff[CNT_W-1:0];

endmodule

// File: rtl/fp_sub_seq.sv
// Multi-cycle single-precision subtractor C = A_FP - B_FP with truncation, one shift per cycle.
// Ports: clock, reset (async high), start/A_FP/B_FP in; busy, done pulse, sign/exponent/mantissa out.
// Latency: done 3+d+s cycles after the start edge; start is ignored unless IDLE (no other backpressure).
module fp_sub_seq
  import fp_defs_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [FP_W-1:0]  A_FP,
  input  logic [FP_W-1:0]  B_FP,
  output logic             busy,
  output logic             done,
  output logic             sign,
  output logic [EXP_W-1:0] exponent,
  output logic [MAN_W-1:0] mantissa
);

  localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(EXP_MAX - 1);
  localparam logic [EXP_W-1:0] EXP_INF = EXP_W'(EXP_MAX);
  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

  state_t state, next_state;

  logic             u_l_sign, u_s_sign;
  logic [EXP_W-1:0] u_l_exp;
  logic [SIG_W-1:0] u_l_sig, u_s_sig;
  logic [CNT_W-1:0] u_diff;

  logic             l_sign_q, s_sign_q;
  logic [EXP_W-1:0] exp_q;
  logic [SIG_W-1:0] l_sig_q, s_sig_q;
  logic [CNT_W-1:0] cnt;
  logic [SIG_W:0]   mag;   // one extra bit for the carry of an effective add

  logic mag_zero, mag_carry, mag_norm;
  logic norm_exit;

  fp_unpack u_unpack (
    .a_fp   (A_FP),
    .b_fp   (B_FP),
    .l_sign (u_l_sign),
    .s_sign (u_s_sign),
    .l_exp  (u_l_exp),
    .l_sig  (u_l_sig),
    .s_sig  (u_s_sig),
    .diff   (u_diff)
  );

  assign mag_zero  = (mag == '0);
  assign mag_carry = mag[SIG_W];
  assign mag_norm  = ~mag[SIG_W] & mag[SIG_W-1];

  // Any condition that finishes normalization this cycle: zero, overflow to Inf,
  // underflow flush, or already normalized.
  assign norm_exit = mag_zero
                   | (mag_carry & (exp_q == EXP_TOP))
                   | (~mag_carry & ~mag[SIG_W-1] & (exp_q == EXP_ONE))
                   | mag_norm;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE:  if (start) next_state = ST_ALIGN;
      ST_ALIGN: begin
        busy = 1'b1;
        if (cnt == '0) next_state = ST_OP;
      end
      ST_OP: begin
        busy       = 1'b1;
        next_state = ST_NORM;
      end
      ST_NORM: begin
        busy = 1'b1;
        if (norm_exit) next_state = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      l_sign_q <= 1'b0;
      s_sign_q <= 1'b0;
      exp_q    <= '0;
      l_sig_q  <= '0;
      s_sig_q  <= '0;
      cnt      <= '0;
      mag      <= '0;
      sign     <= 1'b0;
      exponent <= '0;
      mantissa <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            l_sign_q <= u_l_sign;
            s_sign_q <= u_s_sign;
            exp_q    <= u_l_exp;
            l_sig_q  <= u_l_sig;
            s_sig_q  <= u_s_sig;
            cnt      <= u_diff;
          end
        end
        ST_ALIGN: begin
          // Bits shifted out of S are dropped: truncation, no guard bits.
          if (cnt != '0) begin
            s_sig_q <= s_sig_q >> 1;
            cnt     <= cnt - CNT_W'(1);
          end
        end
        ST_OP: begin
          // |L| >= |S| holds after alignment, so the difference never goes negative.
          if (l_sign_q == s_sign_q) mag <= {1'b0, l_sig_q} + {1'b0, s_sig_q};
          else                      mag <= {1'b0, l_sig_q} - {1'b0, s_sig_q};
        end
        ST_NORM: begin
          if (mag_zero) begin
            sign     <= 1'b0;
            exponent <= '0;
            mantissa <= '0;
          end else if (mag_carry) begin
            if (exp_q == EXP_TOP) begin
              sign     <= l_sign_q;
              exponent <= EXP_INF;
              mantissa <= '0;
            end else begin
              mag   <= mag >> 1;
              exp_q <= exp_q + EXP_W'(1);
            end
          end else if (!mag[SIG_W-1]) begin
            if (exp_q == EXP_ONE) begin
              // Exponent would reach 0: flush to +0.
              sign     <= 1'b0;
              exponent <= '0;
              mantissa <= '0;
            end else begin
              mag   <= mag << 1;
              exp_q <= exp_q - EXP_W'(1);
            end
          end else begin
            sign     <= l_sign_q;
            exponent <= exp_q;
            mantissa <= mag[MAN_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
